// File: rtl/memstream_port_arbiter.sv
// Shares one single-port weight memory between the AXI-Lite config port and
// the memstream read engine. Config always wins. Returning read data is routed
// by a tag pipeline, and stream data is buffered in a credit-protected FIFO.
//
// Handshakes: a stream request transfers on a cycle where strm_valid and
// strm_ready are both high; a stream data word transfers on a cycle where
// strm_ovalid and strm_oready are both high. A source holding valid keeps its
// payload stable until the transfer. Config requests are single-cycle cfg_en
// pulses that are never stalled.
module memstream_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int MEM_LAT    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  cfg_en,
  input  logic                  cfg_wen,
  input  logic [ADDR_WIDTH-1:0] cfg_addr,
  input  logic [DATA_WIDTH-1:0] cfg_wdata,
  output logic                  cfg_rack,
  output logic [DATA_WIDTH-1:0] cfg_rdata,
  input  logic                  strm_valid,
  output logic                  strm_ready,
  input  logic [ADDR_WIDTH-1:0] strm_addr,
  output logic                  strm_ovalid,
  input  logic                  strm_oready,
  output logic [DATA_WIDTH-1:0] strm_odata,
  output logic                  mem_en,
  output logic                  mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW-1:0] CREDIT_MAX = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] PTR_LAST   = PW'(FIFO_DEPTH - 1);

  logic [CW-1:0]         credits;
  logic [CW-1:0]         fifo_cnt;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic                  mem_owner_strm;
  logic [MEM_LAT-1:0]    tag_v;
  logic [MEM_LAT-1:0]    tag_s;
  logic                  strm_acc;
  logic                  strm_pop;
  logic                  ret_v;
  logic                  ret_strm;
  logic                  fifo_push;

  assign strm_ovalid = (fifo_cnt != '0);
  assign strm_pop    = strm_ovalid & strm_oready;
  // A pop in the current cycle frees a credit immediately, so with
  // FIFO_DEPTH >= MEM_LAT+2 the stream never bubbles at full credits.
  assign strm_ready  = aresetn & ~cfg_en & ((credits < CREDIT_MAX) | strm_pop);
  assign strm_acc    = strm_valid & strm_ready;
  // Gated so the data output is zero whenever nothing is being offered.
  assign strm_odata  = strm_ovalid ? fifo_mem[rd_ptr] : '0;
  assign ret_v       = tag_v[MEM_LAT-1];
  assign ret_strm    = tag_s[MEM_LAT-1];
  assign fifo_push   = ret_v & ret_strm;

  // Issue register: the granted request drives the memory port one cycle later.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      mem_en         <= 1'b0;
      mem_wen        <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      mem_owner_strm <= 1'b0;
    end else begin
      mem_en         <= cfg_en | strm_acc;
      mem_wen        <= cfg_en & cfg_wen;
      mem_owner_strm <= ~cfg_en & strm_acc;
      if (cfg_en) begin
        mem_addr  <= cfg_addr;
        mem_wdata <= cfg_wdata;
      end else if (strm_acc) begin
        mem_addr  <= strm_addr;
      end
    end
  end

  // Tag pipeline: {valid, owner} travels alongside each read so it exits
  // exactly when its mem_rdata is valid. Writes enter as invalid.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      tag_v <= '0;
      tag_s <= '0;
    end else begin
      tag_v[0] <= mem_en & ~mem_wen;
      tag_s[0] <= mem_owner_strm;
      for (int i = 1; i < MEM_LAT; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_s[i] <= tag_s[i-1];
      end
    end
  end

  // Config read return: one-cycle rack pulse, data held until the next one.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cfg_rack  <= 1'b0;
      cfg_rdata <= '0;
    end else begin
      cfg_rack <= ret_v & ~ret_strm;
      if (ret_v && !ret_strm) cfg_rdata <= mem_rdata;
    end
  end

  // Stream FIFO storage; contents are only observed through valid entries.
  always_ff @(posedge aclk) begin
    if (fifo_push) fifo_mem[wr_ptr] <= mem_rdata;
  end

  // Stream FIFO pointers and occupancy.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (fifo_push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PW'(1);
      if (strm_pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PW'(1);
      case ({fifo_push, strm_pop})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Credits: stream reads in flight plus words held in the FIFO.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      credits <= '0;
    end else begin
      case ({strm_acc, strm_pop})
        2'b10:   credits <= credits + CW'(1);
        2'b01:   credits <= credits - CW'(1);
        default: credits <= credits;
      endcase
    end
  end

endmodule

// File: tb/tb_memstream_port_arbiter.sv
// Bench for memstream_port_arbiter: behavioural write-first memory with a
// two-cycle read latency, an arbitration vector table, multi-cycle sequences,
// and a scoreboard that predicts stream and config read data.
module tb_memstream_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int LAT = 2;
  localparam int DEPTH = 4;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic          cfg_en, cfg_wen, cfg_rack;
  logic [AW-1:0] cfg_addr;
  logic [DW-1:0] cfg_wdata, cfg_rdata;
  logic          strm_valid, strm_ready, strm_ovalid, strm_oready;
  logic [AW-1:0] strm_addr;
  logic [DW-1:0] strm_odata;
  logic          mem_en, mem_wen;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  memstream_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LAT(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cfg_en(cfg_en), .cfg_wen(cfg_wen), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_rack(cfg_rack), .cfg_rdata(cfg_rdata),
    .strm_valid(strm_valid), .strm_ready(strm_ready), .strm_addr(strm_addr),
    .strm_ovalid(strm_ovalid), .strm_oready(strm_oready), .strm_odata(strm_odata),
    .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Clock
  always #5 aclk = ~aclk;

  function automatic logic [DW-1:0] init_word(input int i);
    return {32'hC0DE_0000 + 32'(i), 32'(i * 7 + 1)};
  endfunction

  // Memory model: write-first, read data valid LAT cycles after the mem_en cycle.
  logic [DW-1:0] mem_model [16];
  logic [DW-1:0] rd_pipe;
  initial begin
    for (int i = 0; i < 16; i++) mem_model[i] = init_word(i);
    rd_pipe   = '0;
    mem_rdata = '0;
    forever begin
      @(posedge aclk);
      if (mem_en && !mem_wen) rd_pipe <= mem_model[mem_addr[3:0]];
      if (mem_en && mem_wen) mem_model[mem_addr[3:0]] <= mem_wdata;
      mem_rdata <= rd_pipe;
    end
  end

  // Scoreboard state
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] cfg_q[$];
  logic [DW-1:0] ref_mem [16];
  logic [DW-1:0] last_strm;
  int checks = 0;
  int errors = 0;
  int n_acc = 0;
  int n_pop = 0;

  typedef struct {
    logic          c_en;
    logic          c_wen;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_wdata;
    logic          s_valid;
    logic [AW-1:0] s_addr;
    logic          exp_ready;
    logic          exp_en;
    logic          exp_wen;
    logic [AW-1:0] exp_addr;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Observe DUT outputs and predict results from the stimulus in this cycle.
  task automatic sb_sample();
    logic [DW-1:0] e;
    if (!aresetn) begin
      exp_q.delete();
      cfg_q.delete();
      return;
    end
    if (strm_ovalid && strm_oready) begin
      n_pop++;
      last_strm = strm_odata;
      if (exp_q.size() == 0) chk("strm_unexpected_word", strm_odata, '0);
      else begin
        e = exp_q.pop_front();
        chk("strm_data", strm_odata, e);
      end
    end
    if (cfg_rack) begin
      if (cfg_q.size() == 0) chk("cfg_unexpected_rack", cfg_rdata, '0);
      else begin
        e = cfg_q.pop_front();
        chk("cfg_rdata", cfg_rdata, e);
      end
    end
    if (strm_valid && strm_ready) begin
      n_acc++;
      exp_q.push_back(ref_mem[strm_addr[3:0]]);
    end
    if (cfg_en) begin
      if (cfg_wen) ref_mem[cfg_addr[3:0]] = cfg_wdata;
      else cfg_q.push_back(ref_mem[cfg_addr[3:0]]);
    end
  endtask

  task automatic half();
    @(negedge aclk);
    sb_sample();
  endtask

  task automatic next();
    @(posedge aclk);
    #1;
  endtask

  task automatic drv(input logic ce, input logic cw, input logic [AW-1:0] ca,
                     input logic [DW-1:0] cd, input logic sv, input logic [AW-1:0] sa);
    cfg_en = ce; cfg_wen = cw; cfg_addr = ca; cfg_wdata = cd;
    strm_valid = sv; strm_addr = sa;
  endtask

  task automatic idle(input int n);
    drv(0, 0, '0, '0, 0, '0);
    for (int i = 0; i < n; i++) begin
      half();
      next();
    end
  endtask

  initial begin
    int sidx;
    int acc0;

    vecs[0] = '{0, 0, 32'd0, 64'd0, 0, 32'd9, 1, 0, 0, 32'd0};
    vecs[1] = '{0, 0, 32'd0, 64'd0, 1, 32'd1, 1, 1, 0, 32'd1};
    vecs[2] = '{1, 0, 32'd5, 64'd0, 1, 32'd2, 0, 1, 0, 32'd5};
    vecs[3] = '{0, 1, 32'd0, 64'd0, 1, 32'd2, 1, 1, 0, 32'd2};
    vecs[4] = '{1, 1, 32'd6, 64'h1111_2222_3333_4444, 1, 32'd7, 0, 1, 1, 32'd6};
    vecs[5] = '{0, 1, 32'd4, 64'd0, 0, 32'd4, 1, 0, 0, 32'd6};
    vecs[6] = '{0, 0, 32'd0, 64'd0, 1, 32'd6, 1, 1, 0, 32'd6};
    vecs[7] = '{1, 0, 32'd6, 64'd0, 0, 32'd0, 0, 1, 0, 32'd6};
    vecs[8] = '{1, 0, 32'd1, 64'd0, 1, 32'd3, 0, 1, 0, 32'd1};
    vecs[9] = '{0, 0, 32'd0, 64'd0, 1, 32'd3, 1, 1, 0, 32'd3};

    for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
    last_strm = '0;

    // Reset
    aresetn = 1'b0;
    strm_oready = 1'b0;
    drv(0, 0, '0, '0, 1, '0);
    repeat (3) half();
    chk("rst_strm_ready", strm_ready, 0);
    chk("rst_strm_ovalid", strm_ovalid, 0);
    chk("rst_cfg_rack", cfg_rack, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_wen", mem_wen, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_strm_odata", strm_odata, 0);
    chk("rst_cfg_rdata", cfg_rdata, 0);
    next();
    aresetn = 1'b1;
    strm_oready = 1'b1;
    idle(2);

    // Arbitration vector table: ready checked in the apply cycle, memory
    // port checked one cycle later.
    for (int k = 0; k <= 10; k++) begin
      if (k < 10) drv(vecs[k].c_en, vecs[k].c_wen, vecs[k].c_addr, vecs[k].c_wdata,
                      vecs[k].s_valid, vecs[k].s_addr);
      else drv(0, 0, '0, '0, 0, '0);
      half();
      if (k < 10) chk($sformatf("vec%0d_strm_ready", k), strm_ready, vecs[k].exp_ready);
      if (k > 0) begin
        chk($sformatf("vec%0d_mem_en", k - 1), mem_en, vecs[k-1].exp_en);
        chk($sformatf("vec%0d_mem_wen", k - 1), mem_wen, vecs[k-1].exp_wen);
        chk($sformatf("vec%0d_mem_addr", k - 1), mem_addr, vecs[k-1].exp_addr);
      end
      next();
    end
    idle(8);

    // Back-to-back stream of addresses 0..7 with the consumer always ready.
    chk("t1_queue_empty", exp_q.size(), 0);
    for (int i = 0; i < 12; i++) begin
      if (i < 8) drv(0, 0, '0, '0, 1, AW'(i));
      else drv(0, 0, '0, '0, 0, '0);
      half();
      if (i < 8) chk($sformatf("t1_ready_%0d", i), strm_ready, 1);
      chk($sformatf("t1_mem_en_%0d", i), mem_en, (i >= 1 && i <= 8));
      chk($sformatf("t1_ovalid_%0d", i), strm_ovalid, (i >= 4));
      next();
    end
    idle(4);

    // Config read cutting into continuous streaming.
    sidx = 0;
    for (int i = 0; i < 14; i++) begin
      drv(i == 3, 0, 32'd5, '0, sidx < 8, AW'(sidx + 8));
      half();
      if (i == 3) chk("t2_ready_blocked", strm_ready, 0);
      if (i == 4) begin
        chk("t2_mem_en", mem_en, 1);
        chk("t2_mem_wen", mem_wen, 0);
        chk("t2_mem_addr", mem_addr, 5);
      end
      chk($sformatf("t2_rack_%0d", i), cfg_rack, i == 7);
      if (strm_valid && strm_ready) sidx++;
      next();
    end
    idle(8);
    chk("t2_stream_complete", exp_q.size(), 0);

    // Backpressure: credits cap accepts at DEPTH, ready returns on first pop.
    strm_oready = 1'b0;
    acc0 = n_acc;
    sidx = 0;
    for (int i = 0; i < 8; i++) begin
      drv(0, 0, '0, '0, 1, AW'(sidx + 4));
      half();
      if (i == 7) chk("t3_ready_full", strm_ready, 0);
      if (strm_valid && strm_ready) sidx++;
      next();
    end
    chk("t3_accepts", n_acc - acc0, DEPTH);
    drv(0, 0, '0, '0, 0, '0);
    strm_oready = 1'b1;
    half();
    chk("t3_ovalid_at_pop", strm_ovalid, 1);
    chk("t3_ready_at_pop", strm_ready, 1);
    next();
    idle(8);
    chk("t3_drained", exp_q.size(), 0);

    // Config write then stream read of the same address next cycle.
    drv(1, 1, 32'd3, 64'hDEAD_BEEF_0000_0001, 0, '0);
    half();
    next();
    drv(0, 0, '0, '0, 1, 32'd3);
    half();
    chk("t4_ready", strm_ready, 1);
    next();
    drv(0, 0, '0, '0, 0, '0);
    for (int i = 0; i < 6; i++) begin
      half();
      chk($sformatf("t4_no_rack_%0d", i), cfg_rack, 0);
      next();
    end
    chk("t4_write_first_data", last_strm, 64'hDEAD_BEEF_0000_0001);

    // Credits = 3 with a simultaneous accept and pop.
    strm_oready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drv(0, 0, '0, '0, 1, AW'(10 + i));
      half();
      chk($sformatf("t5_fill_ready_%0d", i), strm_ready, 1);
      next();
    end
    idle(5);
    drv(0, 0, '0, '0, 1, 32'd13);
    strm_oready = 1'b1;
    half();
    chk("t5_ovalid", strm_ovalid, 1);
    chk("t5_ready_during_swap", strm_ready, 1);
    next();
    strm_oready = 1'b0;
    acc0 = n_acc;
    sidx = 0;
    for (int i = 0; i < 6; i++) begin
      drv(0, 0, '0, '0, 1, AW'(14 + sidx));
      half();
      if (strm_valid && strm_ready) sidx++;
      next();
    end
    chk("t5_one_more_accept", n_acc - acc0, 1);
    strm_oready = 1'b1;
    idle(10);
    chk("t5_drained", exp_q.size(), 0);

    // Reset with two reads in flight and two words in the FIFO.
    strm_oready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drv(0, 0, '0, '0, 1, AW'(1 + i));
      half();
      next();
    end
    idle(5);
    drv(1, 0, 32'd2, '0, 0, '0);
    half();
    next();
    for (int i = 0; i < 2; i++) begin
      drv(0, 0, '0, '0, 1, AW'(3 + i));
      half();
      next();
    end
    aresetn = 1'b0;
    drv(0, 0, '0, '0, 1, '0);
    #1;
    chk("t6_rst_strm_ready", strm_ready, 0);
    chk("t6_rst_ovalid", strm_ovalid, 0);
    chk("t6_rst_odata", strm_odata, 0);
    chk("t6_rst_cfg_rack", cfg_rack, 0);
    chk("t6_rst_cfg_rdata", cfg_rdata, 0);
    chk("t6_rst_mem_en", mem_en, 0);
    chk("t6_rst_mem_addr", mem_addr, 0);
    chk("t6_rst_mem_wdata", mem_wdata, 0);
    half();
    next();
    half();
    next();
    aresetn = 1'b1;
    strm_oready = 1'b1;
    drv(0, 0, '0, '0, 0, '0);
    for (int i = 0; i < 8; i++) begin
      half();
      chk($sformatf("t6_no_ovalid_%0d", i), strm_ovalid, 0);
      chk($sformatf("t6_no_rack_%0d", i), cfg_rack, 0);
      chk($sformatf("t6_ready_%0d", i), strm_ready, 1);
      next();
    end
    drv(0, 0, '0, '0, 1, 32'd9);
    half();
    next();
    idle(8);

    chk("final_strm_queue_empty", exp_q.size(), 0);
    chk("final_cfg_queue_empty", cfg_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
